// File: rtl/hex_display_ctrl.sv
// Registered multi-digit 7-segment driver: holds a loaded hex value and decodes each nibble.
// Supports leading-zero blanking and per-digit blinking driven by an internal prescaler.
module hex_display_ctrl #(
   parameter int DIGITS     = 4,
   parameter int BLINK_DIV  = 25_000_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  lz_en,
   input  logic [DIGITS-1:0]     blink_mask,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int               CNT_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BLINK_DIV - 1);
   localparam logic [6:0]       SEG_BLANK = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

   logic [4*DIGITS-1:0] r_value;
   logic [CNT_W-1:0]    r_blink_cnt;
   logic                r_phase;
   logic [7*DIGITS-1:0] r_hex;

   logic [CNT_W-1:0]    w_cnt_next;
   logic                w_phase_next;
   logic [DIGITS-1:0]   w_lz_blank;
   logic                w_run_zero;
   logic [DIGITS-1:0]   w_blank;
   logic [7*DIGITS-1:0] w_hex_next;

   // Glyph table is written active-low (gfedcba) and inverted for active-high boards.
   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] seg;
      seg = 7'b1111111;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = 7'b1111111;
      endcase
      return ACTIVE_LOW ? seg : ~seg;
   endfunction

   // Prescaler only runs while some digit blinks; otherwise it parks in the visible phase.
   always_comb begin
      w_cnt_next   = '0;
      w_phase_next = 1'b0;
      if (|blink_mask) begin
         if (r_blink_cnt == CNT_MAX) begin
            w_cnt_next   = '0;
            w_phase_next = ~r_phase;
         end else begin
            w_cnt_next   = r_blink_cnt + 1'b1;
            w_phase_next = r_phase;
         end
      end
   end

   // Walk down from the top digit; a digit is blanked while it and everything above it is zero.
   always_comb begin
      w_lz_blank = '0;
      w_run_zero = lz_en;
      for (int i = DIGITS - 1; i > 0; i--) begin
         w_run_zero    = w_run_zero & (r_value[4*i +: 4] == 4'd0);
         w_lz_blank[i] = w_run_zero;
      end
   end

   genvar gi;
   for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_blank[gi]           = w_lz_blank[gi] | (blink_mask[gi] & r_phase);
      assign w_hex_next[7*gi +: 7] = w_blank[gi] ? SEG_BLANK : glyph(r_value[4*gi +: 4]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value     <= '0;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_hex       <= {DIGITS{SEG_BLANK}};
      end else begin
         if (load) begin
            r_value <= value;
         end
         r_blink_cnt <= w_cnt_next;
         r_phase     <= w_phase_next;
         r_hex       <= w_hex_next;
      end
   end

   assign hex = r_hex;

endmodule
